pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives the stall/flush pins of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and the PC write enable.
- Detects load-use hazards, taken-branch flushes, data-memory wait states and halt.
- Keeps saturating performance counters for stall and flush events.

Parameters:
- TIMEOUT, 64, maximum MEM_WAIT cycles before mem_err is raised; range 2..255.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- id_rs  in  4  source register 1 of the instruction in ID.
- id_rt  in  4  source register 2 of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rt  in  1  ID instruction reads id_rt.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  4  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_halt  in  1  HLT instruction is in WB.
- pc_write  out  1  PC register write enable.
- ifid_stall  out  1  hold the IF/ID buffer.
- ifid_flush  out  1  zero the IF/ID buffer.
- idex_stall  out  1  hold the ID/EX buffer.
- idex_flush  out  1  zero the ID/EX buffer (insert bubble).
- exmem_stall  out  1  hold the EX/MEM buffer.
- memwb_flush  out  1  insert bubble into MEM/WB.
- halted  out  1  pipeline is stopped by HLT.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.

Behaviour:
- States are RUN, MEM_WAIT and HALT.
- Reset: state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0, halted=0.
- Control outputs are combinational from state and inputs. Under reset they show the RUN/no-event values: pc_write=1, all other outputs 0.
- Event priority: HALT, then memory wait, then branch, then load-use.
- The ID/EX buffer gives stall priority over flush. This block therefore never asserts idex_stall and idex_flush in the same cycle; the same rule applies to ifid_stall and ifid_flush.
- Load-use hazard (lu): idex_memread & idex_rd!=0 & ((id_uses_rs & id_rs==idex_rd) | (id_uses_rt & id_rt==idex_rd)).
  - Register 0 never causes a hazard.
  - Response, same cycle: pc_write=0, ifid_stall=1, idex_flush=1; exactly one bubble.
  - stall_cnt increments by 1.
- Taken branch in RUN with no memory wait: ifid_flush=1, idex_flush=1, pc_write=1 (PC loads the target). flush_cnt increments by 1.
  - Branch suppresses lu in the same cycle: the ID instruction is discarded, so ifid_stall=0.
- Memory wait is entered when mem_req & !mem_ready in RUN.
  - Same cycle: pc_write=0, ifid_stall=1, idex_stall=1, exmem_stall=1, memwb_flush=1.
  - Branch and lu responses are suppressed that cycle; both are re-evaluated after the wait, because EX and ID are frozen.
  - Next state is MEM_WAIT; the wait counter loads 1.
- MEM_WAIT: same freeze outputs while !mem_ready; wait counter increments; stall_cnt increments each cycle.
  - When mem_ready=1: outputs revert to RUN evaluation that same cycle, state returns to RUN next cycle, wait counter clears.
  - A pending ex_branch_taken or lu is serviced in that release cycle.
  - When the wait counter reaches TIMEOUT: mem_err=1, sticky until reset. The freeze continues; the block does not abort the access.
- mem_req & mem_ready in the same cycle in RUN causes no stall.
- wb_halt=1 in any state: next state is HALT.
  - HALT outputs: pc_write=0, ifid_stall=idex_stall=exmem_stall=1, memwb_flush=1, halted=1.
  - HALT is left only by reset.
- stall_cnt and flush_cnt saturate at all-ones and never wrap.
- Reset asserted mid-MEM_WAIT or mid-HALT returns to RUN immediately; counters clear.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT);
  - REG_ZERO = 4'h0;
  - a packed struct for the buffer control bundle (pc_write, the stall and flush bits).
- One sub-module, sat_counter (CNT_W, inc, asynchronous active-low reset). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Load-use: idex_memread=1, idex_rd=3, id_uses_rs=1, id_rs=3 for 1 cycle -> pc_write=0, ifid_stall=1, idex_flush=1 for that cycle only; stall_cnt=1.
- Register-0 and unused operand: idex_rd=0 with id_rs=0, or id_rt=5 with id_uses_rt=0 and idex_rd=5 -> no stall; outputs stay at RUN values.
- Branch plus load-use: ex_branch_taken=1 and a lu condition in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1, ifid_stall=0; flush_cnt=1, stall_cnt=0.
- Memory wait with deferred branch: mem_req=1, mem_ready=0 for 4 cycles, then 1, with ex_branch_taken=1 throughout -> 4 freeze cycles with no flush, then flush in the release cycle; stall_cnt=4, flush_cnt=1.
- Timeout: TIMEOUT=8, mem_ready held at 0 -> mem_err rises after the 8th wait cycle and stays 1 after mem_ready; a reset pulse clears it.
- Halt and saturation: wb_halt pulse -> halted=1 and all freeze outputs held for 20+ cycles. With CNT_W=4 and 20 stall cycles, stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [3:0] REG_ZERO = 4'h0;
    localparam int         WAIT_W   = 8;

    typedef struct packed {
        logic pc_write;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = ctrl_t'(7'b100_0000);
    localparam ctrl_t CTRL_LU     = ctrl_t'(7'b010_0100);
    localparam ctrl_t CTRL_BRANCH = ctrl_t'(7'b101_0100);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b010_1011);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    function automatic logic load_use(
        input logic       memread,
        input logic [3:0] rd,
        input logic       uses_rs,
        input logic [3:0] rs,
        input logic       uses_rt,
        input logic [3:0] rt
    );
        return memread && (rd != REG_ZERO) &&
               ((uses_rs && (rs == rd)) || (uses_rt && (rt == rd)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Hazard-status inputs and buffer-control outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_rs;
    logic [3:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [3:0]       idex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             wb_halt;

    logic             pc_write;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             memwb_flush;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, idex_memread, idex_rd,
               ex_branch_taken, mem_req, mem_ready, wb_halt,
        output pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, halted, mem_err, stall_cnt, flush_cnt
    );

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, idex_memread, idex_rd,
               ex_branch_taken, mem_req, mem_ready, wb_halt,
        input  pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, halted, mem_err, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that stops at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    output      logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline buffers and PC.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input wire logic          clk,
    input wire logic          rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_mem_err;
    ctrl_t             w_ctrl;
    ctrl_t             w_run_ctrl;
    logic              w_halted;
    logic              w_lu;
    logic              w_mem_stall;
    logic [CNT_W-1:0]  w_stall_cnt;
    logic [CNT_W-1:0]  w_flush_cnt;

    assign w_lu = load_use(bus.idex_memread, bus.idex_rd,
                           bus.id_uses_rs, bus.id_rs,
                           bus.id_uses_rt, bus.id_rt);
    assign w_mem_stall = bus.mem_req && !bus.mem_ready;

    // Normal-flow response; memory freeze outranks branch, branch outranks lu.
    always_comb begin
        w_run_ctrl = CTRL_RUN;
        if (w_mem_stall) begin
            w_run_ctrl = CTRL_FREEZE;
        end else if (bus.ex_branch_taken) begin
            w_run_ctrl = CTRL_BRANCH;
        end else if (w_lu) begin
            w_run_ctrl = CTRL_LU;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = CTRL_RUN;
        w_halted    = 1'b0;
        if (!rst) begin
            w_state_nxt = RUN;
        end else if ((r_state == HALT) || bus.wb_halt) begin
            w_state_nxt = HALT;
            w_ctrl      = CTRL_FREEZE;
            w_halted    = 1'b1;
        end else if ((r_state == MEM_WAIT) && !bus.mem_ready) begin
            w_state_nxt = MEM_WAIT;
            w_ctrl      = CTRL_FREEZE;
        end else begin
            w_ctrl      = w_run_ctrl;
            w_state_nxt = w_mem_stall ? MEM_WAIT : RUN;
        end
    end

    // Wait counter holds at TIMEOUT so it cannot wrap during a long stall.
    always_comb begin
        w_wait_nxt = '0;
        if (w_state_nxt == MEM_WAIT) begin
            if (r_state != MEM_WAIT) begin
                w_wait_nxt = WAIT_W'(1);
            end else if (r_wait_cnt >= C_TIMEOUT) begin
                w_wait_nxt = r_wait_cnt;
            end else begin
                w_wait_nxt = r_wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if ((w_state_nxt == MEM_WAIT) && (w_wait_nxt >= C_TIMEOUT)) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_ctrl.ifid_stall),
        .o_cnt (w_stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_ctrl.ifid_flush),
        .o_cnt (w_flush_cnt)
    );

    assign bus.pc_write    = w_ctrl.pc_write;
    assign bus.ifid_stall  = w_ctrl.ifid_stall;
    assign bus.ifid_flush  = w_ctrl.ifid_flush;
    assign bus.idex_stall  = w_ctrl.idex_stall;
    assign bus.idex_flush  = w_ctrl.idex_flush;
    assign bus.exmem_stall = w_ctrl.exmem_stall;
    assign bus.memwb_flush = w_ctrl.memwb_flush;
    assign bus.halted      = w_halted;
    assign bus.mem_err     = r_mem_err;
    assign bus.stall_cnt   = w_stall_cnt;
    assign bus.flush_cnt   = w_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    // {pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
    localparam logic [6:0] E_RUN = 7'b100_0000;
    localparam logic [6:0] E_LU  = 7'b010_0100;
    localparam logic [6:0] E_BR  = 7'b101_0100;
    localparam logic [6:0] E_FRZ = 7'b010_1011;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl_vec();
        return {bus.pc_write, bus.ifid_stall, bus.ifid_flush, bus.idex_stall,
                bus.idex_flush, bus.exmem_stall, bus.memwb_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_rs           = 4'h0;
        bus.id_rt           = 4'h0;
        bus.id_uses_rs      = 1'b0;
        bus.id_uses_rt      = 1'b0;
        bus.idex_memread    = 1'b0;
        bus.idex_rd         = 4'h0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
        bus.wb_halt         = 1'b0;
    endtask

    // Advance one clock; inputs change and checks happen just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #12;
        rst = 1'b1;
        cyc();
    endtask

    task automatic set_lu(input logic [3:0] rd);
        bus.idex_memread = 1'b1;
        bus.idex_rd      = rd;
        bus.id_uses_rs   = 1'b1;
        bus.id_rs        = rd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        rst = 1'b0;

        // Reset: outputs stay at RUN values even with a hazard on the inputs.
        set_lu(4'd3);
        #7;
        chk("reset_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        chk("reset_halted", 32'(bus.halted), 32'd0);
        chk("reset_mem_err", 32'(bus.mem_err), 32'd0);
        chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        clear_inputs();
        rst = 1'b1;
        cyc();

        // Load-use: exactly one bubble cycle.
        set_lu(4'd3);
        #1;
        chk("lu_ctrl", 32'(ctrl_vec()), 32'(E_LU));
        cyc();
        clear_inputs();
        #1;
        chk("lu_after_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Register 0 and unused operand never stall.
        bus.idex_memread = 1'b1;
        bus.idex_rd      = 4'd0;
        bus.id_uses_rs   = 1'b1;
        bus.id_rs        = 4'd0;
        #1;
        chk("reg0_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        bus.idex_rd    = 4'd5;
        bus.id_rs      = 4'd2;
        bus.id_rt      = 4'd5;
        bus.id_uses_rt = 1'b0;
        #1;
        chk("unused_rt_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        bus.id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_ctrl", 32'(ctrl_vec()), 32'(E_LU));
        cyc();
        clear_inputs();
        #1;
        chk("lu_rt_stall_cnt", 32'(bus.stall_cnt), 32'd2);

        // Branch suppresses a simultaneous load-use.
        do_reset();
        set_lu(4'd3);
        bus.ex_branch_taken = 1'b1;
        #1;
        chk("br_lu_ctrl", 32'(ctrl_vec()), 32'(E_BR));
        cyc();
        clear_inputs();
        #1;
        chk("br_lu_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("br_lu_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // Memory wait of 4 cycles with a branch held pending.
        do_reset();
        bus.mem_req         = 1'b1;
        bus.mem_ready       = 1'b0;
        bus.ex_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("memwait_frz%0d", i), 32'(ctrl_vec()), 32'(E_FRZ));
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("memwait_release_ctrl", 32'(ctrl_vec()), 32'(E_BR));
        cyc();
        clear_inputs();
        #1;
        chk("memwait_after_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        chk("memwait_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        chk("memwait_flush_cnt", 32'(bus.flush_cnt), 32'd1);

        // Same-cycle ready causes no stall.
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("mem_ready_now_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        clear_inputs();

        // Timeout: mem_err rises after the 8th wait cycle and is sticky.
        do_reset();
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        chk("timeout_before", 32'(bus.mem_err), 32'd0);
        cyc();
        chk("timeout_at", 32'(bus.mem_err), 32'd1);
        chk("timeout_still_frz", 32'(ctrl_vec()), 32'(E_FRZ));
        cyc();
        bus.mem_ready = 1'b1;
        #1;
        chk("timeout_release_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        cyc();
        clear_inputs();
        #1;
        chk("timeout_sticky", 32'(bus.mem_err), 32'd1);
        do_reset();
        chk("timeout_reset_clears", 32'(bus.mem_err), 32'd0);

        // Halt holds the freeze; stall count saturates at 15.
        bus.wb_halt = 1'b1;
        cyc();
        bus.wb_halt = 1'b0;
        bus.ex_branch_taken = 1'b1;
        #1;
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_ctrl", 32'(ctrl_vec()), 32'(E_FRZ));
        for (int i = 0; i < 22; i++) cyc();
        chk("halt_hold_halted", 32'(bus.halted), 32'd1);
        chk("halt_hold_ctrl", 32'(ctrl_vec()), 32'(E_FRZ));
        chk("halt_stall_sat", 32'(bus.stall_cnt), 32'd15);
        chk("halt_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        do_reset();
        #1;
        chk("halt_reset_halted", 32'(bus.halted), 32'd0);
        chk("halt_reset_ctrl", 32'(ctrl_vec()), 32'(E_RUN));
        chk("halt_reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
